// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch-request generator with a direct-mapped BTB.
// Latency: fetch_req_o/pred_* are combinational from registered pc/state/BTB; pc, flush_o, misalign_o update at posedge.
// Backpressure: pc holds until fetch_req_o && fetch_ack_i; stall_i suppresses requests; redirect_i wins over everything but rst.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   stall_i                     hold pc, no new requests
//   redirect_i/redirect_addr_i  execute-stage redirect and its target
//   fetch_req_o/fetch_pc_o      fetch request and address toward the IF stage
//   fetch_ack_i                 IF stage accepts the current request
//   pred_taken_o/pred_target_o  BTB prediction for fetch_pc_o
//   flush_o                     one-cycle pulse after a redirect
//   misalign_o                  one-cycle pulse: redirect target had nonzero low bits
//   upd_*                       BTB training from resolved control flow
module pc_fetch_unit #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_VEC   = '0,
    parameter int               INST_BYTES  = 4,
    parameter int               BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            fetch_req_o,
    output logic [XLEN-1:0] fetch_pc_o,
    input  logic            fetch_ack_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            flush_o,
    output logic            misalign_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int OFF  = $clog2(INST_BYTES);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - OFF - IDX;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              misalign_q;

    // BTB storage; only the valid bits are reset.
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    // ------------------------------------------------------------------
    // Lookup on the registered pc
    // ------------------------------------------------------------------
    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;

    assign lk_idx = pc_q[OFF+IDX-1:OFF];
    assign lk_tag = pc_q[XLEN-1:OFF+IDX];
    assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

    assign fetch_req_o   = (state_q == RUN) && !stall_i;
    assign fetch_pc_o    = pc_q;
    assign pred_taken_o  = fetch_req_o && lk_hit && btb_ctr[lk_idx][1];
    assign pred_target_o = (fetch_req_o && lk_hit) ? btb_target[lk_idx] : '0;
    assign flush_o       = (state_q == FLUSH);
    assign misalign_o    = misalign_q;

    // ------------------------------------------------------------------
    // Next-pc selection
    // ------------------------------------------------------------------
    logic            transfer;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] pred_pc;
    logic [XLEN-1:0] seq_pc;
    logic            redir_misaligned;

    assign transfer         = fetch_req_o && fetch_ack_i;
    assign redir_pc         = {redirect_addr_i[XLEN-1:OFF], {OFF{1'b0}}};
    assign pred_pc          = {pred_target_o[XLEN-1:OFF], {OFF{1'b0}}};
    // Natural XLEN-bit wrap past the top of the address space.
    assign seq_pc           = pc_q + XLEN'(INST_BYTES);
    assign redir_misaligned = |redirect_addr_i[OFF-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else if (redirect_i) begin
            // Any same-cycle transfer is dropped; the redirected pc is reissued after FLUSH.
            state_q    <= FLUSH;
            pc_q       <= redir_pc;
            misalign_q <= redir_misaligned;
        end else begin
            misalign_q <= 1'b0;
            if (transfer) begin
                pc_q <= pred_taken_o ? pred_pc : seq_pc;
            end
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     state_q <= RUN;
                FLUSH:   state_q <= RUN;
                default: state_q <= BOOT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // BTB training. Lookup above reads the pre-update contents because
    // the arrays only change at the clock edge.
    // ------------------------------------------------------------------
    logic [IDX-1:0]  up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;

    assign up_idx = upd_pc_i[OFF+IDX-1:OFF];
    assign up_tag = upd_pc_i[XLEN-1:OFF+IDX];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    // Instruction-aligned low bits of the update pc carry no BTB information.
    logic unused_upd_low;
    assign unused_upd_low = ^upd_pc_i[OFF-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    if (btb_ctr[up_idx] != 2'b11) begin
                        btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                    end
                    btb_target[up_idx] <= upd_target_i;
                end else if (btb_ctr[up_idx] != 2'b00) begin
                    btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                end
            end else if (upd_taken_i) begin
                // Allocation evicts whatever aliased into this index.
                btb_valid[up_idx]  <= 1'b1;
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= upd_target_i;
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        fetch_req_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_ack_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        flush_o;
    logic        misalign_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .XLEN(32), .RESET_VEC(32'h100), .INST_BYTES(4), .BTB_ENTRIES(16)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .fetch_req_o(fetch_req_o), .fetch_pc_o(fetch_pc_o), .fetch_ack_i(fetch_ack_i),
        .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .flush_o(flush_o), .misalign_o(misalign_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] raddr;
        logic        ack;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_fl;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic st, input logic rd, input logic [31:0] ra,
                               input logic ak, input logic uv, input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic req, input logic [31:0] pc,
                               input logic pt, input logic [31:0] ptgt, input logic fl, input logic mis);
        vec_t x;
        x.rst = r; x.stall = st; x.redir = rd; x.raddr = ra; x.ack = ak;
        x.uv = uv; x.upc = upc; x.ut = ut; x.utgt = utgt;
        x.e_req = req; x.e_pc = pc; x.e_pt = pt; x.e_ptgt = ptgt; x.e_fl = fl; x.e_mis = mis;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic req, input logic [31:0] pc,
                               input logic pt, input logic [31:0] ptgt, input logic fl, input logic mis);
        chk({tag, " req"},   {31'b0, fetch_req_o},  {31'b0, req});
        chk({tag, " pc"},    fetch_pc_o,            pc);
        chk({tag, " ptk"},   {31'b0, pred_taken_o}, {31'b0, pt});
        chk({tag, " ptgt"},  pred_target_o,         ptgt);
        chk({tag, " flush"}, {31'b0, flush_o},      {31'b0, fl});
        chk({tag, " mis"},   {31'b0, misalign_o},   {31'b0, mis});
    endtask

    task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] ra, input logic ak);
        rst = r; stall_i = st; redirect_i = rd; redirect_addr_i = ra; fetch_ack_i = ak;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // rst, stall, redir, raddr, ack, uv, upc, ut, utgt | req, pc, ptk, ptgt, flush, mis
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h100,0,32'h0,0,0)); // BOOT
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'h100,0,32'h0,0,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'h104,0,32'h0,0,0));
        vecs.push_back(v(0,1,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h108,0,32'h0,0,0)); // stall x3
        vecs.push_back(v(0,1,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h108,0,32'h0,0,0));
        vecs.push_back(v(0,1,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h108,0,32'h0,0,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'h108,0,32'h0,0,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'h10C,0,32'h0,0,0));
        vecs.push_back(v(0,0,1,32'h206,1,      0,32'h0,0,32'h0,     1,32'h110,0,32'h0,0,0)); // redirect + ack
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h204,0,32'h0,1,1));
        vecs.push_back(v(0,0,0,32'h0,1,        1,32'h40,1,32'h80,   1,32'h204,0,32'h0,0,0)); // allocate 0x40
        vecs.push_back(v(0,0,1,32'h40,1,       0,32'h0,0,32'h0,     1,32'h208,0,32'h0,0,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h40,0,32'h0,1,0));  // pred hidden while req=0
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'h40,1,32'h80,0,0)); // predicted taken
        vecs.push_back(v(0,0,1,32'h40,1,       1,32'h40,0,32'h0,    1,32'h80,0,32'h0,0,0));  // not-taken -> ctr 01
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h40,0,32'h0,1,0));
        vecs.push_back(v(0,0,0,32'h0,1,        1,32'h40,1,32'h80,   1,32'h40,0,32'h80,0,0)); // lookup sees pre-update
        vecs.push_back(v(0,0,0,32'h0,0,        0,32'h0,0,32'h0,     1,32'h44,0,32'h0,0,0));  // no ack: hold
        vecs.push_back(v(0,0,1,32'h40,1,       0,32'h0,0,32'h0,     1,32'h44,0,32'h0,0,0));
        vecs.push_back(v(0,0,1,32'h441,1,      0,32'h0,0,32'h0,     0,32'h40,0,32'h0,1,0));  // redirect in FLUSH
        vecs.push_back(v(0,0,0,32'h0,1,        1,32'h440,1,32'h500, 0,32'h440,0,32'h0,1,1)); // alias allocate
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'h440,1,32'h500,0,0));
        vecs.push_back(v(0,0,1,32'h40,1,       0,32'h0,0,32'h0,     1,32'h500,0,32'h0,0,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h40,0,32'h0,1,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'h40,0,32'h0,0,0));  // 0x40 evicted
        vecs.push_back(v(0,0,1,32'hFFFFFFFC,1, 0,32'h0,0,32'h0,     1,32'h44,0,32'h0,0,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'hFFFFFFFC,0,32'h0,1,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'hFFFFFFFC,0,32'h0,0,0));
        vecs.push_back(v(0,0,1,32'h300,1,      0,32'h0,0,32'h0,     1,32'h0,0,32'h0,0,0));   // wrapped
        vecs.push_back(v(1,0,1,32'h700,1,      0,32'h0,0,32'h0,     0,32'h300,0,32'h0,1,0)); // rst in FLUSH w/ redirect
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h100,0,32'h0,0,0)); // BOOT again
        vecs.push_back(v(0,0,1,32'h440,1,      0,32'h0,0,32'h0,     1,32'h100,0,32'h0,0,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     0,32'h440,0,32'h0,1,0));
        vecs.push_back(v(0,0,0,32'h0,1,        0,32'h0,0,32'h0,     1,32'h440,0,32'h0,0,0)); // BTB cleared

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_outputs("reset", 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].raddr, vecs[i].ack);
            upd_valid_i  = vecs[i].uv;
            upd_pc_i     = vecs[i].upc;
            upd_taken_i  = vecs[i].ut;
            upd_target_i = vecs[i].utgt;
            #1;
            chk_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_pt,
                        vecs[i].e_ptgt, vecs[i].e_fl, vecs[i].e_mis);
        end

        // Redirect under stall still wins; requests resume only when stall drops.
        // The last vector acked 0x440 (miss), so pc is now 0x444.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h83, 1'b1);
        #1;
        chk_outputs("stl_redir", 1'b0, 32'h444, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        chk_outputs("stl_flush", 1'b0, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        chk_outputs("stl_hold", 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        chk_outputs("stl_rel", 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_outputs("stl_next", 1'b1, 32'h84, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
